// File: rtl/axi_bresp_scheduler.sv
// AXI B-channel response scheduler: buffers completed write responses and issues them out of order across IDs.
// Latency: a response is issued one cycle after selection; selection waits for occupancy > THRESH or a TIMEOUT idle period.
// Backpressure: in_ready drops at full occupancy; bvalid/bid/bresp hold until bready, then one idle cycle before the next.
//
// Ports:
//   clk, resetn          - rising-edge clock, synchronous active-low reset
//   in_valid/in_ready    - offered write response handshake, with in_id / in_resp payload
//   bvalid/bready        - AXI B channel handshake, with bid / bresp payload
//   count                - number of occupied pending-response slots
module axi_bresp_scheduler #(
  parameter int         DEPTH   = 8,
  parameter int         ID_W    = 2,
  parameter int         THRESH  = 5,
  parameter int         TIMEOUT = 100,
  parameter logic [7:0] SEED    = 8'hA5
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ID_W-1:0]            in_id,
  input  logic [1:0]                 in_resp,
  output logic                       bvalid,
  input  logic                       bready,
  output logic [ID_W-1:0]            bid,
  output logic [1:0]                 bresp,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int TAG_W = IDX_W + 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int NID   = 1 << ID_W;
  localparam int WC_W  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] THRESH_C  = CNT_W'(THRESH);
  localparam logic [WC_W-1:0]  TIMEOUT_C = WC_W'(TIMEOUT);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t state, state_nxt;

  // Slot storage. Tags order same-ID entries; head/tail are per-ID sequence counters
  // one bit wider than the slot index so a full buffer of one ID never aliases.
  logic [DEPTH-1:0] slot_vld;
  logic [ID_W-1:0]  slot_id   [DEPTH];
  logic [1:0]       slot_resp [DEPTH];
  logic [TAG_W-1:0] slot_tag  [DEPTH];
  logic [TAG_W-1:0] head      [NID];
  logic [TAG_W-1:0] tail      [NID];

  logic [7:0]       lfsr;
  logic             lfsr_fb;
  logic [WC_W-1:0]  wait_cnt;

  logic             accept;
  logic             sel;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic [DEPTH-1:0] elig;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] cand;
  logic [CNT_W-1:0] count_nxt;

  assign in_ready = (count < DEPTH_C);
  assign accept   = in_valid && in_ready;
  assign bvalid   = (state == S_HOLD);

  // x^8 + x^6 + x^5 + x^4 + 1, shifting toward the MSB.
  assign lfsr_fb  = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  // Lowest-index free slot. Uses registered valids, so a slot freed by this
  // cycle's selection is not visible to this cycle's accept.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!free_found && !slot_vld[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // A slot may leave only when it is the oldest outstanding entry of its ID.
  // Entries written this cycle are not yet valid, so they become eligible next cycle.
  always_comb begin
    elig = '0;
    for (int i = 0; i < DEPTH; i++) begin
      elig[i] = slot_vld[i] && (slot_tag[i] == head[slot_id[i]]);
    end
  end

  // Randomised round-robin: first eligible slot at or after the LFSR start point.
  // DEPTH is a power of two, so the index adder wraps at DEPTH-1 by itself.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    start      = lfsr[IDX_W-1:0];
    for (int k = 0; k < DEPTH; k++) begin
      cand = start + IDX_W'(k);
      if (!pick_found && elig[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Selection only from IDLE, so the cycle that completes a HOLD handshake never
  // selects and consecutive responses are separated by an idle cycle.
  assign sel = (state == S_IDLE) && pick_found &&
               ((count > THRESH_C) || ((count != '0) && (wait_cnt == TIMEOUT_C)));

  always_comb begin
    count_nxt = count;
    case ({accept, sel})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (sel)    state_nxt = S_HOLD;
      S_HOLD: if (bready) state_nxt = S_IDLE;
      default:            state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      slot_vld <= '0;
      for (int j = 0; j < NID; j++) begin
        head[j] <= '0;
        tail[j] <= '0;
      end
      wait_cnt <= '0;
      count    <= '0;
      bid      <= '0;
      bresp    <= '0;
      lfsr     <= SEED;
    end else begin
      lfsr  <= {lfsr[6:0], lfsr_fb};
      count <= count_nxt;

      if (accept) begin
        slot_vld[free_idx] <= 1'b1;
        tail[in_id]        <= tail[in_id] + TAG_W'(1);
      end

      // free_idx is never a valid slot and pick_idx always is, so these never collide.
      if (sel) begin
        slot_vld[pick_idx]       <= 1'b0;
        head[slot_id[pick_idx]]  <= head[slot_id[pick_idx]] + TAG_W'(1);
        bid                      <= slot_id[pick_idx];
        bresp                    <= slot_resp[pick_idx];
      end

      if ((count == '0) || sel) begin
        wait_cnt <= '0;
      end else if (wait_cnt != TIMEOUT_C) begin
        wait_cnt <= wait_cnt + WC_W'(1);
      end
    end
  end

  // Payload needs no reset: it is qualified by slot_vld everywhere it is read.
  always_ff @(posedge clk) begin
    if (resetn && accept) begin
      slot_id[free_idx]   <= in_id;
      slot_resp[free_idx] <= in_resp;
      slot_tag[free_idx]  <= tail[in_id];
    end
  end

endmodule

// File: tb/tb_axi_bresp_scheduler.sv
// Directed bench for axi_bresp_scheduler with a per-ID ordered scoreboard.
// Latency: checks issue timing against TIMEOUT and THRESH with default parameters.
// Backpressure: exercises bready stalls, full buffer and reset during HOLD.
module tb_axi_bresp_scheduler;

  localparam int DEPTH   = 8;
  localparam int ID_W    = 2;
  localparam int THRESH  = 5;
  localparam int TIMEOUT = 100;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } exp_t;

  logic             clk      = 1'b0;
  logic             resetn   = 1'b0;
  logic             in_valid = 1'b0;
  logic [ID_W-1:0]  in_id    = '0;
  logic [1:0]       in_resp  = '0;
  logic             bready   = 1'b0;
  logic             in_ready;
  logic             bvalid;
  logic [ID_W-1:0]  bid;
  logic [1:0]       bresp;
  logic [CNT_W-1:0] count;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  axi_bresp_scheduler #(
    .DEPTH  (DEPTH),
    .ID_W   (ID_W),
    .THRESH (THRESH),
    .TIMEOUT(TIMEOUT),
    .SEED   (8'hA5)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_id   (in_id),
    .in_resp (in_resp),
    .bvalid  (bvalid),
    .bready  (bready),
    .bid     (bid),
    .bresp   (bresp),
    .count   (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard, sampled mid-cycle: handshakes seen here complete at the next rising edge.
  always @(negedge clk) begin
    if (resetn) begin
      if (bvalid && bready) begin : b_pop
        int   idx;
        exp_t e;
        idx = -1;
        for (int i = 0; i < sb.size(); i++) begin
          if (idx < 0 && sb[i].id == bid) idx = i;
        end
        chk("b_id_outstanding", 32'(idx >= 0), 32'd1);
        if (idx >= 0) begin
          e = sb[idx];
          chk("b_resp_in_order", 32'(bresp), 32'(e.resp));
          sb.delete(idx);
        end
      end
      if (in_valid && in_ready) begin : in_push
        exp_t e;
        e.id   = in_id;
        e.resp = in_resp;
        sb.push_back(e);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic accept(input int id, input int resp);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_id    = ID_W'(id);
    in_resp  = 2'(resp);
    while (!in_ready && n < 50) begin
      cyc(1);
      n++;
    end
    chk("accept_ready", 32'(in_ready), 32'd1);
    cyc(1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int max);
    int n;
    n      = 0;
    bready = 1'b1;
    while ((count != '0 || bvalid) && n < max) begin
      cyc(1);
      n++;
    end
    chk("drain_done", 32'(count == '0 && !bvalid), 32'd1);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int            n;
    logic [ID_W-1:0] bid_h;
    logic [1:0]    bresp_h;

    // Reset with in_valid asserted: must be ignored, in_ready stays high.
    in_valid = 1'b1;
    in_id    = 2'd3;
    cyc(3);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_bid", 32'(bid), 32'd0);
    chk("rst_bresp", 32'(bresp), 32'd0);
    chk("rst_lfsr", 32'(dut.lfsr), 32'hA5);
    in_valid = 1'b0;
    resetn   = 1'b1;
    cyc(1);
    chk("post_rst_count", 32'(count), 32'd0);

    // Lone entry is forced out by the timeout.
    bready = 1'b1;
    accept(1, 0);
    n = 0;
    while (!bvalid && n < 300) begin
      cyc(1);
      n++;
    end
    chk("t1_latency", 32'(n), 32'(TIMEOUT + 1));
    chk("t1_bid", 32'(bid), 32'd1);
    chk("t1_bresp", 32'(bresp), 32'd0);
    cyc(1);
    chk("t1_bvalid_low", 32'(bvalid), 32'd0);
    chk("t1_count", 32'(count), 32'd0);

    // Occupancy above threshold issues without waiting; hold under bready=0.
    bready = 1'b0;
    accept(0, 1); accept(1, 2); accept(2, 3);
    accept(3, 0); accept(0, 2); accept(1, 3);
    chk("t2_count6", 32'(count), 32'd6);
    chk("t2_no_bvalid_yet", 32'(bvalid), 32'd0);
    cyc(1);
    chk("t2_bvalid", 32'(bvalid), 32'd1);
    chk("t2_count5", 32'(count), 32'd5);
    bid_h   = bid;
    bresp_h = bresp;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("t2_hold_bvalid", 32'(bvalid), 32'd1);
      chk("t2_hold_bid", 32'(bid), 32'(bid_h));
      chk("t2_hold_bresp", 32'(bresp), 32'(bresp_h));
      chk("t2_hold_count", 32'(count), 32'd5);
    end
    drain(1500);

    // Same-ID entries leave in acceptance order whatever the LFSR picks.
    bready = 1'b1;
    accept(2, 0); accept(2, 1); accept(2, 2); accept(2, 3);
    chk("t3_count4", 32'(count), 32'd4);
    drain(1500);

    // Fill: accept coinciding with selection at count 6, then up to DEPTH.
    bready = 1'b0;
    for (int i = 0; i < 6; i++) accept(i % 4, (i + 1) % 4);
    chk("t4_count6", 32'(count), 32'd6);
    chk("t4_idle", 32'(bvalid), 32'd0);
    accept(2, 1);
    chk("t4_same_cycle_count", 32'(count), 32'd6);
    chk("t4_same_cycle_bvalid", 32'(bvalid), 32'd1);
    accept(3, 2);
    accept(0, 3);
    chk("t4_full_count", 32'(count), 32'(DEPTH));
    chk("t4_full_ready", 32'(in_ready), 32'd0);
    cyc(3);
    chk("t4_full_ready_held", 32'(in_ready), 32'd0);
    chk("t4_full_count_held", 32'(count), 32'(DEPTH));
    bready = 1'b1;
    cyc(1);
    chk("t4_hs_bvalid", 32'(bvalid), 32'd0);
    chk("t4_hs_ready", 32'(in_ready), 32'd0);
    cyc(1);
    chk("t4_sel_bvalid", 32'(bvalid), 32'd1);
    chk("t4_sel_count", 32'(count), 32'd7);
    chk("t4_sel_ready", 32'(in_ready), 32'd1);
    drain(3000);

    // Reset in the middle of a HOLD discards everything.
    bready = 1'b0;
    accept(0, 0); accept(1, 1); accept(2, 2);
    accept(3, 3); accept(0, 1); accept(1, 2);
    cyc(1);
    chk("t5_hold_bvalid", 32'(bvalid), 32'd1);
    chk("t5_hold_count", 32'(count), 32'd5);
    resetn = 1'b0;
    cyc(1);
    chk("t5_rst_bvalid", 32'(bvalid), 32'd0);
    chk("t5_rst_count", 32'(count), 32'd0);
    chk("t5_rst_lfsr", 32'(dut.lfsr), 32'hA5);
    chk("t5_rst_ready", 32'(in_ready), 32'd1);
    sb.delete();
    resetn = 1'b1;
    cyc(1);
    chk("t5_post_count", 32'(count), 32'd0);
    chk("t5_post_bvalid", 32'(bvalid), 32'd0);
    bready = 1'b1;
    accept(3, 1);
    drain(500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
